// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages; in_ready, out_valid and out_data are all registered.
// Optional synchronous flush is built only when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush
);

  // state | meaning
  // EMPTY | no word held
  // BUSY  | one word, in main
  // FULL  | two words, head in main, second in skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_xfer, out_xfer, flush_act;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_data = main_q;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (flush_act) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) state_nxt = BUSY;
        BUSY: begin
          if (in_xfer && !out_xfer)      state_nxt = FULL;
          else if (!in_xfer && out_xfer) state_nxt = EMPTY;
        end
        FULL:    if (out_xfer) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
    end
  end

  // Registers load only on the listed transfers; everything else holds.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_act) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) main_q <= in_data;
        BUSY: begin
          if (in_xfer && out_xfer) main_q <= in_data;
          else if (in_xfer)        skid_q <= in_data;
        end
        FULL:    if (out_xfer) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks for pipe_skid_reg; flush expectations follow PIPE_SKID_FLUSH_EN.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_stream();
    clr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b out_data=%h want 0 0 0", out_valid, in_ready, out_data);
    end
    #2 clr_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b want 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== i || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: out_valid=%b out_data=%h in_ready=%b want 1 %h 1", i, out_valid, out_data, in_ready, i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single_stall();
    logic [31:0] exp_data [4];
    logic        exp_rdy  [4];
    exp_data = '{32'hA, 32'hA, 32'hB, 32'hC};
    exp_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_data   = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
      out_ready = (i != 1);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data[i] || in_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL single_stall_%0d: out_valid=%b out_data=%h in_ready=%b want 1 %h %b",
                 i, out_valid, out_data, in_ready, exp_data[i], exp_rdy[i]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_stall_drain: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_long_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h100 + i;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL long_stall_%0d: out_valid=%b out_data=%h in_ready=%b want 1 11 0", i, out_valid, out_data, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h22 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL long_drain_1: out_valid=%b out_data=%h in_ready=%b want 1 22 1", out_valid, out_data, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL long_drain_2: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    step();
    in_data = 32'h66;
    step();
    in_valid = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b out_data=%h in_ready=%b want 0 0 0", out_valid, out_data, in_ready);
    end
    #1 clr_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      errors++;
      $display("FAIL reset_mid_recover: out_valid=%b out_data=%h want 1 77", out_valid, out_data);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88;
    step();
    in_data = 32'h99;
    step();
    in_data = 32'hDEADBEEF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL flush_on: out_valid=%b in_ready=%b out_data=%h want 0 1 0", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data === 32'hDEADBEEF) begin
      errors++;
      $display("FAIL flush_after: out_valid=%b out_data=%h want 0 and not deadbeef", out_valid, out_data);
    end
`else
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h88) begin
      errors++;
      $display("FAIL flush_off: out_valid=%b in_ready=%b out_data=%h want 1 0 88", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h99) begin
      errors++;
      $display("FAIL flush_off_drain: out_valid=%b out_data=%h want 1 99", out_valid, out_data);
    end
    step();
`endif
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] head;
    int          bad = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      out_ready = ($urandom_range(1, 0) == 1);
      in_data   = $urandom;
      if (out_valid && out_ready) begin
        head = (q.size() > 0) ? q.pop_front() : 32'hX;
        checks++;
        if (out_data !== head) begin
          errors++;
          if (bad++ < 10) $display("FAIL random_data cyc %0d: out_data=%h want %h", cyc, out_data, head);
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      step();
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        errors++;
        if (bad++ < 10) $display("FAIL random_flags cyc %0d: out_valid=%b in_ready=%b held=%0d", cyc, out_valid, in_ready, q.size());
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset_stream();
    test_single_stall();
    test_long_stall();
    test_reset_mid();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
